neureka_tcdm_responder: RTL and testbench

Memory-side TCDM target that answers the wide HCI requests issued by the NEureka streamer's sources and sink. It holds a word-addressed storage array, grants requests subject to response-queue occupancy and an external stall input, and returns in-order responses with `r_id` and `r_user` echoed. Two uses: a weight-memory/TCDM endpoint in the standalone NEureka subsystem, and a bench target for streamer verification with controllable backpressure.

---
 rtl/neureka_tcdm_responder.sv | 129 ++++++++++++
 tb/tb_neureka_tcdm_responder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neureka_tcdm_responder.sv
// Word-addressed TCDM target that answers HCI requests in order.
// Grants are gated by response-queue occupancy and an external stall.
module neureka_tcdm_responder #(
    parameter int unsigned DW             = 256,
    parameter int unsigned DEPTH          = 64,
    parameter int unsigned IW             = 8,
    parameter int unsigned UW             = 1,
    parameter int unsigned RSP_FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            stall_i,
    input  logic            tcdm_req,
    output logic            tcdm_gnt,
    input  logic [31:0]     tcdm_add,
    input  logic            tcdm_wen,
    input  logic [DW-1:0]   tcdm_data,
    input  logic [DW/8-1:0] tcdm_be,
    input  logic [UW-1:0]   tcdm_user,
    input  logic [IW-1:0]   tcdm_id,
    output logic            tcdm_r_valid,
    input  logic            tcdm_r_ready,
    output logic [DW-1:0]   tcdm_r_data,
    output logic            tcdm_r_opc,
    output logic [IW-1:0]   tcdm_r_id,
    output logic [UW-1:0]   tcdm_r_user,
    output logic [31:0]     num_rd_o,
    output logic [31:0]     num_wr_o
);

    localparam int unsigned BW   = DW / 8;
    localparam int unsigned OFFW = $clog2(BW);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PW   = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int unsigned CW   = $clog2(RSP_FIFO_DEPTH + 1);

    logic [DW-1:0] r_mem [DEPTH];

    logic [DW-1:0] r_rspData [RSP_FIFO_DEPTH];
    logic          r_rspOpc  [RSP_FIFO_DEPTH];
    logic [IW-1:0] r_rspId   [RSP_FIFO_DEPTH];
    logic [UW-1:0] r_rspUser [RSP_FIFO_DEPTH];

    logic [PW-1:0] r_wPtr;
    logic [PW-1:0] r_rPtr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_numRd;
    logic [31:0]   r_numWr;

    logic [AW-1:0] w_idx;
    logic [DW-1:0] w_rdWord;
    logic          w_flush;
    logic          w_accept;
    logic          w_valid;
    logic          w_pop;
    logic          w_unused;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(RSP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Offset and upper address bits are dropped, so addresses wrap over the array.
    assign w_idx    = tcdm_add[OFFW +: AW];
    assign w_unused = ^tcdm_add;
    assign w_rdWord = r_mem[w_idx];

    assign w_flush  = rst_i | clear_i;
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid & tcdm_r_ready;
    assign tcdm_gnt = ~w_flush & ~stall_i & (r_count < CW'(RSP_FIFO_DEPTH));
    assign w_accept = tcdm_req & tcdm_gnt;

    always_ff @(posedge clk_i) begin
        if (w_accept && !tcdm_wen) begin
            for (int b = 0; b < int'(BW); b++) begin
                if (tcdm_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= tcdm_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_rspData[r_wPtr] <= tcdm_wen ? w_rdWord : '0;
            r_rspOpc[r_wPtr]  <= tcdm_wen;
            r_rspId[r_wPtr]   <= tcdm_id;
            r_rspUser[r_wPtr] <= tcdm_user;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_flush) begin
            r_wPtr  <= '0;
            r_rPtr  <= '0;
            r_count <= '0;
            r_numRd <= '0;
            r_numWr <= '0;
        end else begin
            if (w_accept) begin
                r_wPtr <= nextPtr(r_wPtr);
                if (tcdm_wen) begin
                    r_numRd <= r_numRd + 32'd1;
                end else begin
                    r_numWr <= r_numWr + 32'd1;
                end
            end
            if (w_pop) begin
                r_rPtr <= nextPtr(r_rPtr);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Stale entries stay in storage after a flush, so the head is masked when empty.
    assign tcdm_r_valid = w_valid;
    assign tcdm_r_data  = w_valid ? r_rspData[r_rPtr] : '0;
    assign tcdm_r_opc   = w_valid ? r_rspOpc[r_rPtr]  : 1'b0;
    assign tcdm_r_id    = w_valid ? r_rspId[r_rPtr]   : '0;
    assign tcdm_r_user  = w_valid ? r_rspUser[r_rPtr] : '0;
    assign num_rd_o     = r_numRd;
    assign num_wr_o     = r_numWr;

endmodule

// File: tb/tb_neureka_tcdm_responder.sv
// Scoreboard bench for neureka_tcdm_responder: a byte-level memory model predicts
// every response, and a separate monitor pops and compares as responses leave.
module tb_neureka_tcdm_responder;

    localparam int unsigned DW    = 256;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned IW    = 8;
    localparam int unsigned UW    = 1;
    localparam int unsigned FD    = 2;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned TOT   = DEPTH * BW;

    typedef struct {
        logic          opc;
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic [UW-1:0] user;
    } rsp_t;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            clear_i = 1'b0;
    logic            stall_i = 1'b0;
    logic            tcdm_req = 1'b0;
    logic            tcdm_gnt;
    logic [31:0]     tcdm_add = '0;
    logic            tcdm_wen = 1'b1;
    logic [DW-1:0]   tcdm_data = '0;
    logic [BW-1:0]   tcdm_be = '0;
    logic [UW-1:0]   tcdm_user = '0;
    logic [IW-1:0]   tcdm_id = '0;
    logic            tcdm_r_valid;
    logic            tcdm_r_ready;
    logic [DW-1:0]   tcdm_r_data;
    logic            tcdm_r_opc;
    logic [IW-1:0]   tcdm_r_id;
    logic [UW-1:0]   tcdm_r_user;
    logic [31:0]     num_rd_o;
    logic [31:0]     num_wr_o;

    logic [7:0]      refMem [TOT];
    rsp_t            sbQ [$];
    int unsigned     refRd = 0;
    int unsigned     refWr = 0;
    int              nVectors = 0;
    int              nMiscompares = 0;
    int              holdCycles = 0;
    bit              randomReady = 1'b0;
    bit              flushNow = 1'b0;

    neureka_tcdm_responder #(
        .DW(DW), .DEPTH(DEPTH), .IW(IW), .UW(UW), .RSP_FIFO_DEPTH(FD)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .stall_i(stall_i),
        .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add),
        .tcdm_wen(tcdm_wen), .tcdm_data(tcdm_data), .tcdm_be(tcdm_be),
        .tcdm_user(tcdm_user), .tcdm_id(tcdm_id),
        .tcdm_r_valid(tcdm_r_valid), .tcdm_r_ready(tcdm_r_ready),
        .tcdm_r_data(tcdm_r_data), .tcdm_r_opc(tcdm_r_opc),
        .tcdm_r_id(tcdm_r_id), .tcdm_r_user(tcdm_r_user),
        .num_rd_o(num_rd_o), .num_wr_o(num_wr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned baseOf(input logic [31:0] add);
        return ((add % TOT) / BW) * BW;
    endfunction

    function automatic logic [DW-1:0] refRead(input logic [31:0] add);
        logic [DW-1:0] r;
        int unsigned b;
        b = baseOf(add);
        for (int i = 0; i < int'(BW); i++) r[8*i +: 8] = refMem[b + i];
        return r;
    endfunction

    function automatic logic [DW-1:0] randWord();
        logic [DW-1:0] d;
        for (int k = 0; k < int'(DW / 32); k++) d[32*k +: 32] = $urandom();
        return d;
    endfunction

    // Called at the falling edge, before the monitor touches the queue this cycle.
    task automatic cycleChecks();
        logic expGnt;
        expGnt = !rst_i && !clear_i && !stall_i && (sbQ.size() < int'(FD));
        checkOutput("gnt", DW'(tcdm_gnt), DW'(expGnt));
        checkOutput("rValid", DW'(tcdm_r_valid), DW'(sbQ.size() != 0));
        checkOutput("numRd", DW'(num_rd_o), DW'(refRd));
        checkOutput("numWr", DW'(num_wr_o), DW'(refWr));
    endtask

    task automatic acceptModel();
        rsp_t e;
        e.id   = tcdm_id;
        e.user = tcdm_user;
        if (tcdm_wen) begin
            e.opc  = 1'b1;
            e.data = refRead(tcdm_add);
            refRd++;
        end else begin
            e.opc  = 1'b0;
            e.data = '0;
            for (int i = 0; i < int'(BW); i++)
                if (tcdm_be[i]) refMem[baseOf(tcdm_add) + i] = tcdm_data[8*i +: 8];
            refWr++;
        end
        sbQ.push_back(e);
    endtask

    // Holds the request until granted; stall_i is held for the first stallFor cycles.
    task automatic applyStimulus(input logic wen, input logic [31:0] add, input logic [DW-1:0] data,
                                 input logic [BW-1:0] be, input logic [IW-1:0] id,
                                 input logic [UW-1:0] user, input int stallFor, output int waited);
        tcdm_req  = 1'b1;
        tcdm_wen  = wen;
        tcdm_add  = add;
        tcdm_data = data;
        tcdm_be   = be;
        tcdm_id   = id;
        tcdm_user = user;
        waited    = 0;
        for (int c = 0; c < 100; c++) begin
            stall_i = (c < stallFor);
            @(negedge clk_i);
            cycleChecks();
            if (tcdm_gnt) begin
                acceptModel();
                @(posedge clk_i);
                #1;
                stall_i = 1'b0;
                return;
            end
            waited++;
            @(posedge clk_i);
            #1;
        end
        checkOutput("gntTimeout", DW'(0), DW'(1));
        tcdm_req = 1'b0;
        stall_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        tcdm_req = 1'b0;
        repeat (n) begin
            @(negedge clk_i);
            cycleChecks();
            @(posedge clk_i);
            #1;
        end
    endtask

    // A write is presented during the flush cycle; it must be neither granted nor stored.
    task automatic pulseFlush(input bit isReset);
        if (isReset) rst_i = 1'b1;
        else clear_i = 1'b1;
        tcdm_req  = 1'b1;
        tcdm_wen  = 1'b0;
        tcdm_add  = '0;
        tcdm_data = randWord();
        tcdm_be   = '1;
        @(negedge clk_i);
        cycleChecks();
        flushNow = 1'b1;
        sbQ.delete();
        refRd = 0;
        refWr = 0;
        @(posedge clk_i);
        #1;
        rst_i    = 1'b0;
        clear_i  = 1'b0;
        flushNow = 1'b0;
        tcdm_req = 1'b0;
        @(negedge clk_i);
        checkOutput("flushRValid", DW'(tcdm_r_valid), DW'(0));
        checkOutput("flushRData", tcdm_r_data, '0);
        checkOutput("flushRId", DW'(tcdm_r_id), DW'(0));
        checkOutput("flushROpc", DW'(tcdm_r_opc), DW'(0));
        cycleChecks();
        @(posedge clk_i);
        #1;
    endtask

    initial begin : readyDriver
        tcdm_r_ready = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (holdCycles > 0) begin
                holdCycles--;
                tcdm_r_ready = 1'b0;
            end else begin
                tcdm_r_ready = randomReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    initial begin : monitor
        logic held;
        rsp_t heldV;
        rsp_t e;
        held = 1'b0;
        forever begin
            @(negedge clk_i);
            #1;
            if (flushNow || rst_i) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                checkOutput("stableValid", DW'(tcdm_r_valid), DW'(1));
                checkOutput("stableData", tcdm_r_data, heldV.data);
                checkOutput("stableId", DW'(tcdm_r_id), DW'(heldV.id));
                checkOutput("stableOpc", DW'(tcdm_r_opc), DW'(heldV.opc));
            end
            if (tcdm_r_valid && tcdm_r_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedRsp", DW'(1), DW'(0));
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("rspOpc", DW'(tcdm_r_opc), DW'(e.opc));
                    checkOutput("rspData", tcdm_r_data, e.data);
                    checkOutput("rspId", DW'(tcdm_r_id), DW'(e.id));
                    checkOutput("rspUser", DW'(tcdm_r_user), DW'(e.user));
                end
            end
            held = tcdm_r_valid && !tcdm_r_ready;
            heldV.data = tcdm_r_data;
            heldV.id   = tcdm_r_id;
            heldV.opc  = tcdm_r_opc;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int waited;
        logic [DW-1:0] w0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("resetRValid", DW'(tcdm_r_valid), DW'(0));
        checkOutput("resetRData", tcdm_r_data, '0);
        checkOutput("resetNumRd", DW'(num_rd_o), DW'(0));
        checkOutput("resetNumWr", DW'(num_wr_o), DW'(0));
        checkOutput("resetGnt", DW'(tcdm_gnt), DW'(1));
        @(posedge clk_i);
        #1;

        $display("[TB] preload every word");
        for (int w = 0; w < int'(DEPTH); w++)
            applyStimulus(1'b0, 32'(w * BW), randWord(), '1, IW'(w), '0, 0, waited);
        pulseFlush(1'b0);

        $display("[TB] write then read back");
        applyStimulus(1'b0, 32'h40, {BW{8'hA5}}, '1, 8'd7, 1'b1, 0, waited);
        applyStimulus(1'b1, 32'h40, '0, '0, 8'd3, 1'b0, 0, waited);
        idle(3);
        checkOutput("wrReadNumWr", DW'(num_wr_o), DW'(1));
        checkOutput("wrReadNumRd", DW'(num_rd_o), DW'(1));

        $display("[TB] partial byte enables");
        applyStimulus(1'b0, 32'(5 * BW), {BW{8'hFF}}, '1, 8'd10, 1'b0, 0, waited);
        applyStimulus(1'b0, 32'(5 * BW), '0, BW'(1), 8'd11, 1'b0, 0, waited);
        applyStimulus(1'b1, 32'(5 * BW), '0, '0, 8'd12, 1'b0, 0, waited);
        idle(3);

        $display("[TB] backpressure with full queue");
        holdCycles = 1000;
        idle(2);
        applyStimulus(1'b1, 32'h40, '0, '0, 8'd1, 1'b0, 0, waited);
        applyStimulus(1'b1, 32'(5 * BW), '0, '0, 8'd2, 1'b0, 0, waited);
        holdCycles = 5;
        applyStimulus(1'b1, 32'h0, '0, '0, 8'd3, 1'b0, 0, waited);
        idle(4);

        $display("[TB] stall with request held");
        applyStimulus(1'b1, 32'h40, '0, '0, 8'd20, 1'b0, 5, waited);
        checkOutput("stallWait", DW'(waited), DW'(5));
        idle(2);

        $display("[TB] address wrap");
        w0 = randWord();
        applyStimulus(1'b0, 32'h0, w0, '1, 8'd30, 1'b0, 0, waited);
        applyStimulus(1'b1, 32'(64 * 32), '0, '0, 8'd31, 1'b0, 0, waited);
        idle(3);

        $display("[TB] clear mid-flight");
        holdCycles = 1000;
        idle(2);
        applyStimulus(1'b1, 32'h40, '0, '0, 8'd40, 1'b0, 0, waited);
        applyStimulus(1'b1, 32'h0, '0, '0, 8'd41, 1'b0, 0, waited);
        pulseFlush(1'b0);
        holdCycles = 0;
        idle(2);
        applyStimulus(1'b1, 32'h0, '0, '0, 8'd42, 1'b0, 0, waited);
        idle(3);

        $display("[TB] randomized traffic");
        randomReady = 1'b1;
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom()), $urandom(), randWord(), BW'({$urandom(), $urandom()}),
                          IW'($urandom()), UW'($urandom()),
                          ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, waited);
            if ($urandom_range(0, 9) == 0) idle(1);
            if (n % 131 == 130) pulseFlush(n % 2 == 0);
        end
        randomReady = 1'b0;
        idle(8);
        checkOutput("drained", DW'(sbQ.size()), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
